// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM state encoding and data width.
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane steering: extracts and extends load data, and merges store data into a word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        lane_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merged_o = word_i;
    case (size_i)
      SZ_B: begin
        load_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        load_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-organised data memory (sync write, async read).
// Optional misalignment/out-of-range trapping is enabled with `define LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic [2:0]        dbg_state
);

  // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid pulses for exactly one cycle with no
  // backpressure, so the consumer must take the response in that cycle.

  state_e            state_q, state_d;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              uns_q;
  logic              err_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q, merged_q, rdata_q;

  logic        accept;
  logic        err_now;
  logic [1:0]  size_eff;
  logic [1:0]  lane_eff;
  logic [31:0] load_data, merged_data;

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    size_eff = req_size;
    lane_eff = req_addr[1:0];
    err_now  = (req_size == SZ_X)
            || (req_size == SZ_H && req_addr[0])
            || (req_size == SZ_W && req_addr[1:0] != 2'b00)
            || (req_addr[31:ADDR_W+2] != '0);
  end
`else
  // Upper address bits simply wrap the index, so they play no part here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    err_now  = 1'b0;
    size_eff = (req_size == SZ_X) ? SZ_W : req_size;
    case (size_eff)
      SZ_B:    lane_eff = req_addr[1:0];
      SZ_H:    lane_eff = {req_addr[1], 1'b0};
      default: lane_eff = 2'b00;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (err_now)           state_d = RESP;
          else if (!req_we)      state_d = LOAD;
          else if (size_eff == SZ_W) state_d = WRITE;
          else                   state_d = MERGE;
        end
      end
      LOAD:    state_d = RESP;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= size_eff;
        lane_q  <= lane_eff;
        uns_q   <= req_unsigned;
        err_q   <= err_now;
        idx_q   <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state_q == LOAD)  rdata_q  <= load_data;
      if (state_q == MERGE) merged_q <= merged_data;
    end
  end

  // One lane mux serves both the LOAD extract and the MERGE read-modify-write.
  lsu_lane_mux u_lane_mux (
    .word_i     (mem_rd),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .lane_i     (lane_q),
    .unsigned_i (uns_q),
    .load_o     (load_data),
    .merged_o   (merged_data)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;
  assign mem_we     = (state_q == WRITE) && rst;
  assign mem_addr   = (state_q == LOAD || state_q == MERGE || state_q == WRITE) ? idx_q : '0;
  assign mem_wd     = !mem_we ? '0 : (size_q == SZ_W) ? wdata_q : merged_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: memory model plus a byte-level reference of expected responses.
// Build with +define+LSU_MISALIGN_TRAP_EN to exercise the trapping configuration.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 10;
  localparam int RW        = 65;
  localparam int WW        = 32 + ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err, mem_we;
  logic [31:0]       resp_rdata, mem_wd, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        dbg_state;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .dbg_state(dbg_state)
  );

  // Data memory seen by the DUT, and the reference image the model maintains.
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;
  assign mem_rd = mem[mem_addr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];   // {resp cycle, err, rdata}
  logic [WW-1:0] wr_q[$];    // {write cycle, index, data}
  int busy_from = 1, busy_to = 0;
  bit skip_ready = 1'b0;
  int resp_count = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [RW-1:0] e;
    logic [WW-1:0] w;
    if (!mem_we) check("mem_wd_zero_when_idle", mem_wd, 32'h0);
    if (mem_we) begin
      if (wr_q.size() == 0) check("unexpected_mem_we", 32'(mem_we), 32'h0);
      else begin
        w = wr_q.pop_front();
        check("write_cycle", cyc, w[WW-1 -: 32]);
        check("write_index", 32'(mem_addr), 32'(w[ADDR_W+31:32]));
        check("write_data", mem_wd, w[31:0]);
      end
    end else if (wr_q.size() != 0 && int'(wr_q[0][WW-1 -: 32]) <= cyc) begin
      w = wr_q.pop_front();
      check("missing_mem_we", 32'(mem_we), 32'h1);
    end
    if (resp_valid) begin
      resp_count++;
      last_rdata = resp_rdata;
      last_err   = resp_err;
      if (exp_q.size() == 0) check("unexpected_resp_valid", 32'(resp_valid), 32'h0);
      else begin
        e = exp_q.pop_front();
        check("resp_cycle", cyc, e[RW-1 -: 32]);
        check("resp_rdata", resp_rdata, e[31:0]);
        check("resp_err", 32'(resp_err), 32'(e[32]));
      end
    end else if (exp_q.size() != 0 && int'(exp_q[0][RW-1 -: 32]) <= cyc) begin
      e = exp_q.pop_front();
      check("missing_resp_valid", 32'(resp_valid), 32'h1);
    end
    if (rst && !skip_ready)
      check("req_ready", 32'(req_ready), 32'(!(cyc >= busy_from && cyc <= busy_to)));
    if (rst && req_ready) check("mem_addr_idle", 32'(mem_addr), 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  task automatic wait_ready(output bit ok);
    int b = 0;
    while (!req_ready && b < 20) begin @(negedge clk); b++; end
    ok = req_ready;
    if (!ok) check("accept_timeout", 32'(req_ready), 32'h1);
  endtask

  // Presents one request at a negedge, records the model's expectations at acceptance,
  // and returns on the negedge after the accepting edge with req_valid still high.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, output int n);
    bit ok, err;
    int nb, idx, off, lat;
    logic [31:0] a, v, w;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    wait_ready(ok);
    n = cyc;
    if (ok) begin
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err = (sz == 2'b11) || (addr % nb != 0) || (addr >= 32'(4 * MEM_WORDS));
`endif
      a   = addr - (addr % nb);
      idx = int'((a >> 2) % MEM_WORDS);
      off = int'(a % 4);
      if (err) begin
        exp_q.push_back({32'(n + 1), 1'b1, 32'h0});
        busy_to = n + 1;
      end else if (!we) begin
        v = ref_mem[idx] >> (8 * off);
        if (nb < 4) begin
          v = v % (32'd1 << (8 * nb));
          if (!uns && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        end
        exp_q.push_back({32'(n + 2), 1'b0, v});
        busy_to = n + 2;
      end else begin
        w = ref_mem[idx];
        for (int b = 0; b < nb; b++)
          w = (w & ~(32'hFF << (8 * (off + b)))) | (((wd >> (8 * b)) & 32'hFF) << (8 * (off + b)));
        ref_mem[idx] = w;
        lat = (nb == 4) ? 1 : 2;
        wr_q.push_back({32'(n + lat), ADDR_W'(idx), w});
        exp_q.push_back({32'(n + lat + 1), 1'b0, 32'h0});
        busy_to = n + lat + 1;
      end
      busy_from = n + 1;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic finish_req();
    int b = 0;
    req_valid = 1'b0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && b < 20) begin @(negedge clk); b++; end
    if (exp_q.size() != 0) check("resp_drain_timeout", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic req1(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n;
    do_req(we, sz, uns, addr, wd, n);
    finish_req();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0, n1, n2, n3, rc0, bad;
    bit ok;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < MEM_WORDS; i++) poke(i, 32'h0);

    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_resp_err", 32'(resp_err), 32'h0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Sub-word loads with sign/zero extension.
    poke(7, 32'h8899AABB);
    req1(0, SZ_B, 0, 32'h1D, 0); check("lb_0x1D", last_rdata, 32'hFFFFFFAA);
    req1(0, SZ_B, 1, 32'h1D, 0); check("lbu_0x1D", last_rdata, 32'h000000AA);
    req1(0, SZ_H, 0, 32'h1E, 0); check("lh_0x1E", last_rdata, 32'hFFFF8899);
    req1(0, SZ_H, 1, 32'h1E, 0); check("lhu_0x1E", last_rdata, 32'h00008899);
    req1(0, SZ_B, 0, 32'h1C, 0); check("lb_0x1C", last_rdata, 32'hFFFFFFBB);
    req1(0, SZ_H, 0, 32'h1C, 0); check("lh_0x1C", last_rdata, 32'hFFFFAABB);

    // Byte store read-modify-write.
    poke(7, 32'h11223344);
    req1(1, SZ_B, 0, 32'h1D, 32'h55);
    check("sb_mem7", mem[7], 32'h11225544);
    check("sb_rdata", last_rdata, 32'h0);

    // Word store and read back.
    req1(1, SZ_W, 0, 32'h70, 32'hDEADBEEF);
    check("sw_mem28", mem[28], 32'hDEADBEEF);
    req1(0, SZ_W, 0, 32'h70, 0); check("lw_0x70", last_rdata, 32'hDEADBEEF);

    // Misaligned word load, size 11 and an out-of-range address.
    req1(0, SZ_W, 0, 32'h72, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_0x72_err", 32'(last_err), 32'h1);
    check("lw_0x72_rdata", last_rdata, 32'h0);
`else
    check("lw_0x72_rdata", last_rdata, 32'hDEADBEEF);
    check("lw_0x72_err", 32'(last_err), 32'h0);
`endif
    req1(0, SZ_X, 0, 32'h70, 0);
    req1(0, SZ_W, 0, 32'h1070, 0);

    // Half/byte stores to word 9, including a misaligned half.
    req1(1, SZ_H, 0, 32'h26, 32'hFFFFCAFE);
    req1(0, SZ_H, 0, 32'h26, 0); check("lh_0x26", last_rdata, 32'hFFFFCAFE);
    req1(1, SZ_B, 0, 32'h24, 32'h80);
    req1(0, SZ_B, 1, 32'h24, 0); check("lbu_0x24", last_rdata, 32'h00000080);
    req1(0, SZ_B, 0, 32'h24, 0); check("lb_0x24", last_rdata, 32'hFFFFFF80);
    req1(1, SZ_H, 0, 32'h25, 32'h1234);
    req1(0, SZ_W, 0, 32'h24, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_0x24_after_trap", last_rdata, 32'hCAFE0080);
`else
    check("lw_0x24_after_sh25", last_rdata, 32'hCAFE1234);
`endif
    req1(1, SZ_X, 0, 32'h30, 32'h0BADF00D);

    // Reset while the half store is in its WRITE cycle.
    skip_ready = 1'b1;
    poke(8, 32'hA5A5A5A5);
    rc0 = resp_count;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_H; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h1234;
    wait_ready(ok);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_test_in_write", 32'(dbg_state), 32'(WRITE));
    rst = 1'b0; #1;
    check("rst_gates_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_ready_after", 32'(req_ready), 32'h1);
    repeat (4) @(negedge clk);
    check("rst_no_resp", resp_count, rc0);
    check("rst_mem8_unchanged", mem[8], 32'hA5A5A5A5);
    skip_ready = 1'b0;

    // Back-to-back loads with req_valid held high.
    rc0 = resp_count;
    do_req(0, SZ_B, 0, 32'h1D, 0, n0);
    do_req(0, SZ_B, 1, 32'h1F, 0, n1);
    do_req(0, SZ_H, 0, 32'h26, 0, n2);
    do_req(0, SZ_W, 0, 32'h70, 0, n3);
    finish_req();
    check("b2b_spacing_1", n1 - n0, 3);
    check("b2b_spacing_2", n2 - n1, 3);
    check("b2b_spacing_3", n3 - n2, 3);
    check("b2b_resp_count", resp_count - rc0, 4);
    check("b2b_last", last_rdata, 32'hDEADBEEF);

    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
